// File: rtl/mult_unit.sv
// Iterative signed WIDTHxWIDTH shift-add multiplier. Latency: WIDTH CALC cycles, then a one-cycle DONE pulse.
// New requests are not accepted while busy: start_i is ignored in CALC and DONE, and busy_o asks the issue stage to stall.
module mult_unit #(
  parameter int          WIDTH     = 32,
  parameter logic [3:0]  MULT_CODE = 4'b1000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH:0]     acc_q, acc_d;
  logic                 sign_q, sign_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH:0]     acc_step;
  logic                 last_step;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      sign_q   <= 1'b0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      sign_q   <= sign_d;
      prod_q   <= prod_d;
    end
  end

  always_comb begin
    // The accumulator MSB is always 0 after a shift, so it only carries the add overflow.
    sum       = acc_q[2*WIDTH:WIDTH] + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    acc_step  = {1'b0, sum, acc_q[WIDTH-1:1]};
    last_step = (cnt_q == CW'(WIDTH - 1));

    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    sign_d   = sign_q;
    prod_d   = prod_q;

    case (state_q)
      IDLE: begin
        if (start_i && (ALUCtrl_i == MULT_CODE)) begin
          mcand_d  = src1_i[WIDTH-1] ? -src1_i : src1_i;
          mplier_d = src2_i[WIDTH-1] ? -src2_i : src2_i;
          sign_d   = src1_i[WIDTH-1] ^ src2_i[WIDTH-1];
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d    = acc_step;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (last_step) begin
          prod_d  = sign_q ? -acc_step[2*WIDTH-1:0] : acc_step[2*WIDTH-1:0];
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign result_o    = prod_q[WIDTH-1:0];
  assign result_hi_o = prod_q[2*WIDTH-1:WIDTH];
  assign busy_o      = (state_q == CALC);
  assign done_o      = (state_q == DONE);

endmodule

// File: tb/tb_mult_unit.sv
// Bench for mult_unit: cycle-level reference model plus directed vectors with literal expectations.
module tb_mult_unit;
  localparam int         W    = 32;
  localparam logic [3:0] MULT = 4'b1000;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic [3:0]   ALUCtrl_i = 4'b0000;
  logic [W-1:0] src1_i = '0;
  logic [W-1:0] src2_i = '0;
  logic [W-1:0] result_o, result_hi_o;
  logic         busy_o, done_o;

  int n_total = 0;
  int n_bad   = 0;

  mult_unit #(.WIDTH(W), .MULT_CODE(MULT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .ALUCtrl_i(ALUCtrl_i),
    .src1_i(src1_i), .src2_i(src2_i), .result_o(result_o),
    .result_hi_o(result_hi_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycles elapsed since accept, and the arithmetic product.
  int          m_phase = 0;
  logic [63:0] m_pend  = '0;
  logic [63:0] m_res   = '0;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_phase = 0;
      m_res   = '0;
    end else if (m_phase == 0) begin
      if (start_i && ALUCtrl_i == MULT) begin
        m_pend  = longint'($signed(src1_i)) * longint'($signed(src2_i));
        m_phase = 1;
      end
    end else if (m_phase < W) begin
      m_phase++;
    end else if (m_phase == W) begin
      m_phase = W + 1;
      m_res   = m_pend;
    end else begin
      m_phase = 0;
    end
  end

  always @(negedge clk_i) begin
    chk("model_busy", 64'(busy_o), 64'(m_phase >= 1 && m_phase <= W));
    chk("model_done", 64'(done_o), 64'(m_phase == W + 1));
    chk("model_hi",   64'(result_hi_o), 64'(m_res[63:32]));
    chk("model_lo",   64'(result_o),    64'(m_res[31:0]));
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk_i); #1;
    start_i = 1'b1; ALUCtrl_i = MULT; src1_i = a; src2_i = b;
    @(posedge clk_i); #1;
    start_i = 1'b0; ALUCtrl_i = 4'b0000;
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] eh, input logic [W-1:0] el, input bit inject);
    int cyc;
    bit got;
    issue(a, b);
    cyc = 0;
    got = 0;
    while (cyc < 40 && !got) begin
      @(negedge clk_i);
      cyc++;
      if (inject && cyc == 10) begin
        start_i = 1'b1; ALUCtrl_i = MULT; src1_i = 9; src2_i = 9;
      end
      if (inject && cyc == 11) begin
        start_i = 1'b0; ALUCtrl_i = 4'b0000;
      end
      if (done_o) got = 1;
    end
    chk("done_seen",  64'(got), 64'd1);
    chk("done_cycle", 64'(cyc), 64'd33);
    chk("lit_hi", 64'(result_hi_o), 64'(eh));
    chk("lit_lo", 64'(result_o), 64'(el));
  endtask

  initial begin
    int dones;
    // reset state
    repeat (2) @(negedge clk_i);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_lo",   64'(result_o), 64'd0);
    chk("rst_hi",   64'(result_hi_o), 64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    run(32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F, 0);
    run(-32'sd7, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 0);
    run(32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0);
    run(32'h8000_0000, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run(32'd0, -32'sd5, 32'h0000_0000, 32'h0000_0000, 0);
    run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 0);
    run(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 0);

    // Non-multiply code: never busy, result holds.
    @(posedge clk_i); #1;
    start_i = 1'b1; ALUCtrl_i = 4'b0010; src1_i = 4; src2_i = 4;
    repeat (5) begin
      @(negedge clk_i);
      chk("nonmult_busy", 64'(busy_o), 64'd0);
      chk("nonmult_done", 64'(done_o), 64'd0);
    end
    start_i = 1'b0; ALUCtrl_i = 4'b0000;
    chk("nonmult_lo", 64'(result_o), 64'h1);
    chk("nonmult_hi", 64'(result_hi_o), 64'h3FFF_FFFF);

    // Second request during CALC is dropped.
    run(32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F, 1);
    run(32'd9, 32'd9, 32'h0000_0000, 32'h0000_0051, 0);

    // Asynchronous reset mid-multiply.
    issue(32'd3, 32'd5);
    repeat (12) @(negedge clk_i);
    #1 rst_i = 1'b1;
    #1;
    chk("arst_busy", 64'(busy_o), 64'd0);
    chk("arst_done", 64'(done_o), 64'd0);
    chk("arst_lo",   64'(result_o), 64'd0);
    chk("arst_hi",   64'(result_hi_o), 64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (done_o) dones++;
    end
    chk("arst_no_done", 64'(dones), 64'd0);
    run(32'd2, 32'd2, 32'h0000_0000, 32'h0000_0004, 0);

    repeat (3) @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
